// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: CPU bus front end of a mode-0 PPI. Synchronises the strobes and
// holds the control word, port output latches and per-bit direction vectors.
module ppi_bus_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CTRL_RESET  = 8'h9B,
  parameter bit          CLR_ON_MODE = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CS_N,
  input  logic       RD_N,
  input  logic       WR_N,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOUT_EN,
  input  logic [7:0] PA_IN,
  input  logic [7:0] PB_IN,
  input  logic [7:0] PC_IN,
  output logic [7:0] PA_OUT,
  output logic [7:0] PB_OUT,
  output logic [7:0] PC_OUT,
  output logic [7:0] PA_DIR,
  output logic [7:0] PB_DIR,
  output logic [7:0] PC_DIR,
  output logic       MODE_ERR
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0] cs_sync_q, cs_sync_d;
  logic [SS-1:0] rd_sync_q, rd_sync_d;
  logic [SS-1:0] wr_sync_q, wr_sync_d;
  logic          cs_prev_q, wr_prev_q;
  logic [1:0]    a_cap_q, a_cap_d;
  logic [7:0]    d_cap_q, d_cap_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    pa_out_q, pa_out_d;
  logic [7:0]    pb_out_q, pb_out_d;
  logic [7:0]    pc_out_q, pc_out_d;
  logic          mode_err_q, mode_err_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          cs_s, rd_s, wr_s, wr_commit_s, rd_act_s;

  // Input pins where the bit is an input, output latch where it is an output.
  function automatic logic [7:0] pin_mux(input logic [7:0] pin, input logic [7:0] lat,
                                         input logic [7:0] dir);
    return (pin & dir) | (lat & ~dir);
  endfunction

  // Synchroniser shifts, write capture, write commit and registered read path.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SS-2:0], CS_N};
    rd_sync_d   = {rd_sync_q[SS-2:0], RD_N};
    wr_sync_d   = {wr_sync_q[SS-2:0], WR_N};
    cs_s        = cs_sync_q[SS-1];
    rd_s        = rd_sync_q[SS-1];
    wr_s        = wr_sync_q[SS-1];
    wr_commit_s = wr_s & ~wr_prev_q & ~cs_prev_q;
    rd_act_s    = ~cs_s & ~rd_s & wr_s;

    a_cap_d    = a_cap_q;
    d_cap_d    = d_cap_q;
    ctrl_d     = ctrl_q;
    pa_out_d   = pa_out_q;
    pb_out_d   = pb_out_q;
    pc_out_d   = pc_out_q;
    mode_err_d = mode_err_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;

    if (!cs_s && !wr_s) begin
      a_cap_d = A;
      d_cap_d = DIN;
    end else begin
      a_cap_d = a_cap_q;
      d_cap_d = d_cap_q;
    end

    if (wr_commit_s) begin
      case (a_cap_q)
        2'd0: pa_out_d = d_cap_q;
        2'd1: pb_out_d = d_cap_q;
        2'd2: pc_out_d = d_cap_q;
        2'd3: begin
          if (d_cap_q[7]) begin
            // Only mode 0 for both groups is supported; anything else is flagged.
            if ((d_cap_q[6:5] == 2'b00) && !d_cap_q[2]) begin
              ctrl_d = d_cap_q;
              if (CLR_ON_MODE) begin
                pa_out_d = 8'h00;
                pb_out_d = 8'h00;
                pc_out_d = 8'h00;
              end else begin
                pa_out_d = pa_out_q;
              end
            end else begin
              mode_err_d = 1'b1;
            end
          end else begin
            pc_out_d[d_cap_q[3:1]] = d_cap_q[0];
          end
        end
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end

    if (rd_act_s) begin
      dout_en_d = 1'b1;
      case (A)
        2'd0:    dout_d = pin_mux(PA_IN, pa_out_q, PA_DIR);
        2'd1:    dout_d = pin_mux(PB_IN, pb_out_q, PB_DIR);
        2'd2:    dout_d = pin_mux(PC_IN, pc_out_q, PC_DIR);
        2'd3:    dout_d = ctrl_q;
        default: dout_d = 8'h00;
      endcase
    end else begin
      dout_en_d = 1'b0;
      dout_d    = dout_q;
    end
  end

  // State registers; synchronisers restart at 1 so strobes read as inactive.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync_q  <= {SS{1'b1}};
      rd_sync_q  <= {SS{1'b1}};
      wr_sync_q  <= {SS{1'b1}};
      cs_prev_q  <= 1'b1;
      wr_prev_q  <= 1'b1;
      a_cap_q    <= 2'd0;
      d_cap_q    <= 8'h00;
      ctrl_q     <= CTRL_RESET;
      pa_out_q   <= 8'h00;
      pb_out_q   <= 8'h00;
      pc_out_q   <= 8'h00;
      mode_err_q <= 1'b0;
      dout_q     <= 8'h00;
      dout_en_q  <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      rd_sync_q  <= rd_sync_d;
      wr_sync_q  <= wr_sync_d;
      cs_prev_q  <= cs_s;
      wr_prev_q  <= wr_s;
      a_cap_q    <= a_cap_d;
      d_cap_q    <= d_cap_d;
      ctrl_q     <= ctrl_d;
      pa_out_q   <= pa_out_d;
      pb_out_q   <= pb_out_d;
      pc_out_q   <= pc_out_d;
      mode_err_q <= mode_err_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
    end
  end

  assign PA_DIR   = {8{ctrl_q[4]}};
  assign PB_DIR   = {8{ctrl_q[1]}};
  assign PC_DIR   = {{4{ctrl_q[3]}}, {4{ctrl_q[0]}}};
  assign PA_OUT   = pa_out_q;
  assign PB_OUT   = pb_out_q;
  assign PC_OUT   = pc_out_q;
  assign MODE_ERR = mode_err_q;
  assign DOUT     = dout_q;
  assign DOUT_EN  = dout_en_q;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Self-checking bench for ppi_bus_ctrl: reference model of the register file
// plus a read-data scoreboard popped on each DOUT_EN rising edge.
module tb_ppi_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [1:0] a = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'h00;
  logic [7:0] dout, pa_out, pb_out, pc_out, pa_dir, pb_dir, pc_dir;
  logic       dout_en, mode_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_ctrl, m_pa, m_pb, m_pc;
  logic       m_err;
  logic [7:0] sb_q[$];
  logic       en_prev = 1'b0;

  ppi_bus_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .CS_N(cs_n), .RD_N(rd_n), .WR_N(wr_n),
    .A(a), .DIN(din), .DOUT(dout), .DOUT_EN(dout_en),
    .PA_IN(pa_in), .PB_IN(pb_in), .PC_IN(pc_in),
    .PA_OUT(pa_out), .PB_OUT(pb_out), .PC_OUT(pc_out),
    .PA_DIR(pa_dir), .PB_DIR(pb_dir), .PC_DIR(pc_dir),
    .MODE_ERR(mode_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dir_a(input logic [7:0] c); return {8{c[4]}}; endfunction
  function automatic logic [7:0] dir_b(input logic [7:0] c); return {8{c[1]}}; endfunction
  function automatic logic [7:0] dir_c(input logic [7:0] c); return {{4{c[3]}}, {4{c[0]}}}; endfunction

  function automatic logic [7:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return (pa_in & dir_a(m_ctrl)) | (m_pa & ~dir_a(m_ctrl));
      2'd1:    return (pb_in & dir_b(m_ctrl)) | (m_pb & ~dir_b(m_ctrl));
      2'd2:    return (pc_in & dir_c(m_ctrl)) | (m_pc & ~dir_c(m_ctrl));
      default: return m_ctrl;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h9B; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00; m_err = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] sel, input logic [7:0] d);
    case (sel)
      2'd0: m_pa = d;
      2'd1: m_pb = d;
      2'd2: m_pc = d;
      default: begin
        if (d[7]) begin
          if (d[6:5] == 2'b00 && !d[2]) begin
            m_ctrl = d; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
          end else begin
            m_err = 1'b1;
          end
        end else begin
          m_pc[d[3:1]] = d[0];
        end
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".pa_out"}, pa_out, m_pa);
    check_eq({tag, ".pb_out"}, pb_out, m_pb);
    check_eq({tag, ".pc_out"}, pc_out, m_pc);
    check_eq({tag, ".pa_dir"}, pa_dir, dir_a(m_ctrl));
    check_eq({tag, ".pb_dir"}, pb_dir, dir_b(m_ctrl));
    check_eq({tag, ".pc_dir"}, pc_dir, dir_c(m_ctrl));
    check_eq({tag, ".mode_err"}, {7'd0, mode_err}, {7'd0, m_err});
  endtask

  // Normal write; commit must land exactly on the third rising edge after WR_N rises.
  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    a = sel; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_regs("wr_pre");
    @(posedge clk);
    model_write(sel, d);
    #1 check_regs("wr_post");
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] sel);
    @(negedge clk);
    a = sel; cs_n = 1'b0; rd_n = 1'b0;
    sb_q.push_back(model_read(sel));
    repeat (2) @(posedge clk);
    #1 check_eq("rd_lat_early", {7'd0, dout_en}, 8'h00);
    @(posedge clk);
    #1 check_eq("rd_lat_en", {7'd0, dout_en}, 8'h01);
    repeat (2) @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("rd_rel_hold", {7'd0, dout_en}, 8'h01);
    @(posedge clk);
    #1 check_eq("rd_rel_off", {7'd0, dout_en}, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard: every new read-data window pops one expected byte.
  always @(negedge clk) begin
    if (dout_en && !en_prev) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_read", {7'd0, dout_en}, 8'h00);
      end else begin
        check_eq("sb_dout", dout, sb_q.pop_front());
      end
    end
    en_prev <= dout_en;
  end

  initial begin
    logic [1:0] rs;
    logic [7:0] rd;
    model_reset();
    #23 rst_n = 1'b1;
    @(negedge clk);
    check_regs("reset");
    check_eq("reset.dout", dout, 8'h00);
    check_eq("reset.dout_en", {7'd0, dout_en}, 8'h00);

    cpu_write(2'd3, 8'h80);
    cpu_write(2'd0, 8'hA5);
    pa_in = 8'h3C;
    cpu_read(2'd0);

    cpu_write(2'd3, 8'h89);
    pa_in = 8'h5A; pc_in = 8'h3C;
    cpu_read(2'd2);
    cpu_read(2'd3);
    cpu_read(2'd0);

    cpu_write(2'd2, 8'h66);
    cpu_write(2'd3, 8'h0F);
    cpu_write(2'd3, 8'h04);
    cpu_read(2'd3);

    cpu_write(2'd3, 8'hA0);
    cpu_write(2'd3, 8'h84);
    cpu_write(2'd3, 8'h82);
    pb_in = 8'hC3;
    cpu_read(2'd1);
    cpu_write(2'd2, 8'h11);

    // CS_N released before WR_N rises: nothing may change.
    @(negedge clk);
    a = 2'd0; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_n = 1'b1;
    repeat (5) @(negedge clk);
    check_regs("cs_early");

    // RD_N and WR_N low together: no read data, write to PB still commits.
    @(negedge clk);
    a = 2'd1; din = 8'h5A; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rw_both.dout_en", {7'd0, dout_en}, 8'h00);
    end
    wr_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(posedge clk);
    model_write(2'd1, 8'h5A);
    #1 check_regs("rw_both");
    check_eq("rw_both.pb", pb_out, 8'h5A);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_regs("async_rst");
    check_eq("async_rst.dout_en", {7'd0, dout_en}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_read(2'd3);

    for (int i = 0; i < 8; i++) begin
      rs = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      cpu_write(rs, rd);
      pa_in = 8'($urandom); pb_in = 8'($urandom); pc_in = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      cpu_read(rs);
    end

    repeat (4) @(negedge clk);
    check_eq("sb_left", 8'(sb_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
